antares_load_store_unit: RTL and testbench

MEM-stage data-port controller for the Antares MIPS32 pipeline. It takes load/store requests from the EX/MEM stage, runs a request/ready transaction on the data port, and formats load data for the MEM/WB pipeline register. It holds the pipeline through `mem_request_stall` until the transaction finishes. Misaligned accesses and bus errors are reported as exception flags.

---
 rtl/antares_load_store_unit.sv | 141 ++++++++++++++
 tb/tb_antares_load_store_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/antares_load_store_unit.sv
// MEM-stage data-port controller: issues one request/ready bus transaction per
// load/store, formats big-endian load data and holds the pipeline until done.
module antares_load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic        mem_mem_byte,
  input  logic        mem_mem_halfword,
  input  logic        mem_mem_sign_extend,
  input  logic        mem_flush,
  input  logic        stall_pipeline,
  input  logic [31:0] dport_data_i,
  input  logic        dport_ready,
  input  logic        dport_error,
  output logic [31:0] dport_address,
  output logic [31:0] dport_data_o,
  output logic [3:0]  dport_wr,
  output logic        dport_enable,
  output logic [31:0] mem_read_data,
  output logic        mem_request_stall,
  output logic        exc_address_error_load,
  output logic        exc_address_error_store,
  output logic        exc_bus_error
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_next;
  logic        req, misaligned, valid_req, flushed;
  logic        flush_seen, bus_error;
  logic        is_byte, is_half, sign_ext;
  logic [1:0]  lane;
  logic [3:0]  wr_calc;
  logic [31:0] store_calc, load_calc;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign req        = (mem_mem_read | mem_mem_write) & ~mem_flush;
  assign misaligned = mem_mem_byte     ? 1'b0 :
                      mem_mem_halfword ? mem_address[0] : (mem_address[1:0] != 2'b00);
  assign valid_req  = req & ~misaligned;
  assign flushed    = flush_seen | mem_flush;

  assign exc_address_error_store = (state == IDLE) & req & misaligned & mem_mem_write;
  assign exc_address_error_load  = (state == IDLE) & req & misaligned & ~mem_mem_write;
  assign exc_bus_error           = (state == DONE) & bus_error;
  assign mem_request_stall       = ((state == IDLE) & valid_req) | (state == WAIT);

  // Store lanes: big-endian, lane 0 is bits [31:24].
  always_comb begin
    wr_calc    = 4'b1111;
    store_calc = mem_store_data;
    if (mem_mem_byte) begin
      wr_calc    = 4'b1000 >> mem_address[1:0];
      store_calc = {4{mem_store_data[7:0]}};
    end else if (mem_mem_halfword) begin
      wr_calc    = mem_address[1] ? 4'b0011 : 4'b1100;
      store_calc = {2{mem_store_data[15:0]}};
    end
  end

  // Load formatting uses the access shape captured at issue time.
  always_comb begin
    load_byte = dport_data_i[31:24];
    case (lane)
      2'd1:    load_byte = dport_data_i[23:16];
      2'd2:    load_byte = dport_data_i[15:8];
      2'd3:    load_byte = dport_data_i[7:0];
      default: load_byte = dport_data_i[31:24];
    endcase
    load_half = lane[1] ? dport_data_i[15:0] : dport_data_i[31:16];
    if (is_byte)
      load_calc = {{24{sign_ext & load_byte[7]}}, load_byte};
    else if (is_half)
      load_calc = {{16{sign_ext & load_half[15]}}, load_half};
    else
      load_calc = dport_data_i;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid_req) state_next = WAIT;
      WAIT:    if (dport_ready) state_next = flushed ? IDLE : DONE;
      DONE:    if (!stall_pipeline) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dport_address <= 32'd0;
      dport_data_o  <= 32'd0;
      dport_wr      <= 4'd0;
      dport_enable  <= 1'b0;
      mem_read_data <= 32'd0;
      bus_error     <= 1'b0;
      flush_seen    <= 1'b0;
      is_byte       <= 1'b0;
      is_half       <= 1'b0;
      sign_ext      <= 1'b0;
      lane          <= 2'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (valid_req) begin
            dport_address <= {mem_address[31:2], 2'b00};
            dport_data_o  <= store_calc;
            dport_wr      <= mem_mem_write ? wr_calc : 4'd0;
            dport_enable  <= 1'b1;
            is_byte       <= mem_mem_byte;
            is_half       <= mem_mem_halfword & ~mem_mem_byte;
            sign_ext      <= mem_mem_sign_extend;
            lane          <= mem_address[1:0];
            flush_seen    <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_flush) flush_seen <= 1'b1;
          if (dport_ready) begin
            dport_enable <= 1'b0;
            dport_wr     <= 4'd0;
            flush_seen   <= 1'b0;
            // A squashed instruction still completes on the bus, but its result is dropped.
            if (!flushed) begin
              mem_read_data <= dport_error ? 32'd0 : load_calc;
              bus_error     <= dport_error;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_antares_load_store_unit.sv
// Directed and randomized checks of antares_load_store_unit against a
// byte-lane arithmetic model of the big-endian data port.
module tb_antares_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_address = '0, mem_store_data = '0, dport_data_i = '0;
  logic        mem_mem_read = 0, mem_mem_write = 0, mem_mem_byte = 0, mem_mem_halfword = 0;
  logic        mem_mem_sign_extend = 0, mem_flush = 0, stall_pipeline = 0;
  logic        dport_ready = 0, dport_error = 0;
  logic [31:0] dport_address, dport_data_o, mem_read_data;
  logic [3:0]  dport_wr;
  logic        dport_enable, mem_request_stall;
  logic        exc_address_error_load, exc_address_error_store, exc_bus_error;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_rd = '0;
  bit          model_rd_known = 1'b1;

  always #5 clk = ~clk;

  antares_load_store_unit dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_store_data(mem_store_data),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_mem_byte(mem_mem_byte),
    .mem_mem_halfword(mem_mem_halfword), .mem_mem_sign_extend(mem_mem_sign_extend),
    .mem_flush(mem_flush), .stall_pipeline(stall_pipeline), .dport_data_i(dport_data_i),
    .dport_ready(dport_ready), .dport_error(dport_error), .dport_address(dport_address),
    .dport_data_o(dport_data_o), .dport_wr(dport_wr), .dport_enable(dport_enable),
    .mem_read_data(mem_read_data), .mem_request_stall(mem_request_stall),
    .exc_address_error_load(exc_address_error_load),
    .exc_address_error_store(exc_address_error_store), .exc_bus_error(exc_bus_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: bytes touched are lanes addr..addr+size-1, lane 0 = MSB.
  function automatic logic [3:0] m_wr(input int sz, input logic [31:0] a);
    logic [3:0] m = 4'd0;
    int off = int'(a % 4);
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + sz) m[3-i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_dout(input int sz, input logic [31:0] d);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      r = (r << 8) | ((d >> (8 * ((3 - i) % sz))) & 32'hFF);
    return r;
  endfunction

  function automatic logic [31:0] m_load(input int sz, input bit sgn, input logic [31:0] a,
                                         input logic [31:0] d);
    longint unsigned mask = (64'd1 << (8 * sz)) - 1;
    longint unsigned v = (longint'(d) >> (8 * (4 - int'(a % 4) - sz))) & mask;
    if (sgn && sz < 4 && v[8*sz-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic drive(input bit wr, input int sz, input bit sgn, input logic [31:0] a,
                       input logic [31:0] sd);
    mem_mem_write = wr;  mem_mem_read = ~wr;
    mem_mem_byte = (sz == 1);  mem_mem_halfword = (sz == 2);
    mem_mem_sign_extend = sgn;  mem_address = a;  mem_store_data = sd;
  endtask

  task automatic idle_inputs();
    mem_mem_write = 0; mem_mem_read = 0; mem_mem_byte = 0; mem_mem_halfword = 0;
    mem_mem_sign_extend = 0; mem_address = '0; mem_store_data = '0;
  endtask

  // One access: wn wait states, optional bus error, optional 4-cycle hold in DONE.
  task automatic access(input bit wr, input int sz, input bit sgn, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int wn,
                        input bit err, input bit hold);
    bit mis = (a % sz) != 0;
    int stall_cnt = 0;
    logic [31:0] exp_rd;
    @(negedge clk);
    drive(wr, sz, sgn, a, sd);
    dport_ready = 0;
    #1;
    if (mis) begin
      chk("exc_load", exc_address_error_load, !wr);
      chk("exc_store", exc_address_error_store, wr);
      chk("mis_stall", mem_request_stall, 0);
      @(posedge clk); #1;
      chk("mis_enable", dport_enable, 0);
      idle_inputs();
      $display("[TB] %s sz=%0d addr=%h misaligned", wr ? "store" : "load", sz, a);
      return;
    end
    chk("exc_none", {exc_address_error_load, exc_address_error_store}, 0);
    if (mem_request_stall) stall_cnt++;
    for (int i = 0; i <= wn; i++) begin
      @(negedge clk);
      if (mem_request_stall) stall_cnt++;
      chk("enable", dport_enable, 1);
      chk("address", dport_address, a & 32'hFFFF_FFFC);
      chk("wr", dport_wr, wr ? m_wr(sz, a) : 4'd0);
      if (wr) chk("data_o", dport_data_o, m_dout(sz, sd));
      if (i == wn) begin
        dport_ready = 1; dport_data_i = rd; dport_error = err;
      end else begin
        dport_data_i = $urandom;
      end
    end
    @(negedge clk);
    dport_ready = 0; dport_error = 0;
    exp_rd = err ? 32'd0 : m_load(sz, sgn, a, rd);
    chk("stall_cycles", stall_cnt, wn + 2);
    chk("done_stall", mem_request_stall, 0);
    chk("done_enable", dport_enable, 0);
    chk("done_wr", dport_wr, 0);
    chk("bus_error", exc_bus_error, err);
    if (!wr) chk("read_data", mem_read_data, exp_rd);
    model_rd = exp_rd;
    model_rd_known = !wr;
    if (hold) begin
      stall_pipeline = 1;
      drive(0, 4, 0, 32'h200, 0);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("hold_enable", dport_enable, 0);
        chk("hold_stall", mem_request_stall, 0);
        chk("hold_error", exc_bus_error, err);
        if (!wr) chk("hold_data", mem_read_data, exp_rd);
      end
      stall_pipeline = 0;
    end
    idle_inputs();
    $display("[TB] %s sz=%0d sgn=%0d addr=%h sd=%h rd=%h wait=%0d err=%0d -> rdata=%h",
             wr ? "store" : "load", sz, sgn, a, sd, rd, wn, err, mem_read_data);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_outputs", {dport_address, dport_data_o, dport_wr, dport_enable, mem_read_data[0],
                        mem_request_stall, exc_address_error_load, exc_address_error_store,
                        exc_bus_error} == '0, 1);
    chk("rst_read_data", mem_read_data, 0);
    @(negedge clk); rst = 0;

    // Test-plan directed steps
    access(0, 4, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0);
    access(0, 1, 1, 32'h103, 0, 32'h123456F0, 0, 0, 0);
    access(0, 1, 0, 32'h103, 0, 32'h123456F0, 1, 0, 0);
    access(1, 2, 0, 32'h102, 32'h0000ABCD, 0, 3, 0, 0);
    access(0, 4, 0, 32'h101, 0, 0, 0, 0, 0);
    access(1, 2, 0, 32'h001, 32'h1234, 0, 0, 0, 0);
    access(0, 2, 1, 32'h042, 0, 32'h00008001, 1, 0, 0);
    access(0, 4, 0, 32'h020, 0, 32'h55AA55AA, 1, 1, 1);

    // Flush during WAIT; ready two cycles later with an error that must be discarded
    access(0, 4, 0, 32'h040, 0, 32'h11223344, 0, 0, 0);
    @(negedge clk); drive(0, 4, 0, 32'h080, 0); #1;
    chk("fl_issue_stall", mem_request_stall, 1);
    @(negedge clk); chk("fl_enable0", dport_enable, 1); mem_flush = 1; #1;
    chk("fl_stall0", mem_request_stall, 1);
    @(negedge clk); mem_flush = 0; chk("fl_enable1", dport_enable, 1);
    chk("fl_stall1", mem_request_stall, 1);
    @(negedge clk); chk("fl_enable2", dport_enable, 1); chk("fl_stall2", mem_request_stall, 1);
    dport_ready = 1; dport_data_i = 32'hCAFEF00D; dport_error = 1; idle_inputs();
    @(negedge clk); dport_ready = 0; dport_error = 0;
    chk("fl_done_enable", dport_enable, 0);
    chk("fl_no_stall", mem_request_stall, 0);
    chk("fl_no_buserr", exc_bus_error, 0);
    chk("fl_data_kept", mem_read_data, 32'h11223344);
    drive(0, 4, 0, 32'h300, 0); #1;
    chk("fl_back_idle", mem_request_stall, 1);
    #1 idle_inputs();
    $display("[TB] flush during wait: rdata=%h", mem_read_data);

    // Ready and flush in the same WAIT cycle
    @(negedge clk); drive(0, 4, 0, 32'h0C0, 0);
    @(negedge clk); dport_ready = 1; dport_data_i = 32'h99999999; mem_flush = 1;
    @(negedge clk); dport_ready = 0; mem_flush = 0; idle_inputs();
    chk("rf_no_stall", mem_request_stall, 0);
    chk("rf_enable", dport_enable, 0);
    chk("rf_data_kept", mem_read_data, 32'h11223344);
    $display("[TB] ready+flush same cycle: rdata=%h", mem_read_data);

    // Asynchronous reset in WAIT
    @(negedge clk); drive(1, 4, 0, 32'h400, 32'h87654321);
    @(negedge clk); chk("rs_enable_before", dport_enable, 1);
    #2 idle_inputs(); rst = 1; #1;
    chk("rs_enable", dport_enable, 0);
    chk("rs_outputs", {dport_address, dport_data_o, dport_wr, mem_read_data, mem_request_stall,
                       exc_address_error_load, exc_address_error_store, exc_bus_error} == '0, 1);
    @(negedge clk); rst = 0; drive(0, 4, 0, 32'h10, 0); #1;
    chk("rs_idle", mem_request_stall, 1);
    #1 idle_inputs();
    $display("[TB] reset in wait: enable=%0d", dport_enable);

    // Randomized accesses against the model
    for (int n = 0; n < 40; n++) begin
      int sz;
      logic [31:0] a;
      case ($urandom_range(0, 2)) 0: sz = 1; 1: sz = 2; default: sz = 4; endcase
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      access($urandom_range(0, 1), sz, $urandom_range(0, 1), a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
